uart_lite_16550: RTL and testbench
==================================

Name: uart_lite_16550

Overview:
- Memory-mapped UART slave at 0x10000000–0x100000FF, on the bus fabric's UART slave port (req/we/addr/wdata/wstrb → rdata/ready).
- Provides the 8250/16550 register subset that the OpenSBI uart8250 driver uses (reg-shift 2, reg-io-width 4).
- Includes a TX FIFO, a 16x-oversampled RX with a single holding register, a programmable baud divisor and a level interrupt.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of 2, minimum 2.
- DEFAULT_DIV, 16'd27, reset divisor. Each 16x tick lasts divisor clk cycles (27 gives about 115200 baud at 50 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req  in  1  access request, held until ready
- we  in  1  1 = write, 0 = read
- addr  in  32  byte address; only addr[4:2] decoded
- wdata  in  32  write data; register byte is wdata[7:0]
- wstrb  in  4  write strobes; a write takes effect only if wstrb[0] = 1
- rdata  out  32  {24'h0, reg}; valid while ready = 1
- ready  out  1  single-cycle access completion
- uart_tx  out  1  serial out, idle high
- uart_rx  in  1  serial in, asynchronous
- irq  out  1  level interrupt

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - rdata = 0, ready = 0, uart_tx = 1, irq = 0.
  - FIFO empty; DLL/DLM = DEFAULT_DIV; IER, LCR, MCR, SCR = 0.
  - DR = OE = FE = 0; TX and RX state machines IDLE.
  - Reset mid-frame aborts the frame; uart_tx returns high the next cycle.
- Handshake:
  - An access is accepted on a cycle where req = 1 and ready = 0.
  - ready = 1 exactly one cycle later (1 wait state), with rdata registered. ready is then 0 on the following cycle.
  - A req still high in the cycle where ready = 1 is not accepted. A new access may be accepted on the cycle after ready.
  - Side effects (FIFO push, RX pop, OE clear) occur once, on the accept cycle.
- Register map (addr[4:2]):
  - 0 with DLAB = 0: read RBR (pops: DR ← 0); write THR (push to FIFO). A push while the FIFO is full is dropped.
  - 0 with DLAB = 1: DLL read/write.
  - 1 with DLAB = 0: IER read/write; bits [1:0] stored, upper bits read 0.
  - 1 with DLAB = 1: DLM read/write.
  - 2 read: IIR = 8'hC4 if ERBFI & DR; else 8'hC2 if ETBEI & THRE; else 8'hC1.
  - 2 write: FCR. bit1 clears RX (DR, OE ← 0); bit2 empties the TX FIFO. The frame in progress completes.
  - 3: LCR read/write, all 8 bits stored. Only bit7 (DLAB) is functional; format is fixed 8N1.
  - 4: MCR read/write (stored only). 5: LSR read-only. 6: MSR reads 8'h00. 7: SCR read/write.
  - Writes to read-only locations are ignored.
- LSR:
  - bit0 DR; bit1 OE; bit3 FE; bit5 THRE = FIFO empty; bit6 TEMT = FIFO empty and TX IDLE; other bits 0.
  - Reading LSR clears OE and FE on the accept cycle.
- Baud:
  - A tick counter counts 0 .. div−1 and pulses tick16 at wrap, with div = {DLM, DLL}.
  - div = 0 is treated as 1.
  - Writing DLL or DLM restarts the counter at 0.
- TX state machine: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE.
  - Each bit lasts 16 tick16 pulses.
  - In IDLE with the FIFO non-empty, it pops the byte and enters START on the next tick16.
  - Back-to-back bytes produce no idle gap beyond tick alignment.
  - A THR push and a TX pop in the same cycle are both honoured; the count is unchanged.
- RX:
  - uart_rx passes through a 2-flop synchronizer.
  - IDLE → START on a falling edge. START is checked at tick 8; if high, the sampler returns to IDLE (glitch rejection).
  - DATA: 8 samples taken at mid-bit (every 16 ticks). STOP: sampled at mid-bit; FE is set if the stop bit is 0.
  - At STOP the byte is written to RBR and DR ← 1. If DR was already 1, OE ← 1 and RBR is overwritten.
  - If an RBR pop and a byte write occur in the same cycle, the new byte wins: DR = 1 and no OE is set.
- Interrupt: irq is registered, irq = (IER[0] & DR) | (IER[1] & THRE). It updates one cycle after a state change.

Test Plan:
- Reset, then read LSR (addr 0x10000014) → rdata = 0x60; ready = 1 for exactly one cycle, one cycle after accept; uart_tx = 1; irq = 0.
- Write DLAB = 1, DLL = 2, DLM = 0, DLAB = 0, then THR = 0x55 → uart_tx shows start bit, 1,0,1,0,1,0,1,0, stop bit. Each bit lasts 32 clk; TEMT returns to 1 after the stop bit.
- With div = 1, push TX_DEPTH + 2 bytes (0x00..0x11) quickly → the first TX_DEPTH + 1 are transmitted in order (one is already in the shifter when the FIFO fills), the last is dropped; THRE = 0 until the FIFO drains.
- Drive RX frame 0xA3 at div × 16 clk per bit → DR = 1, RBR reads 0xA3, then DR = 0. Send two frames without reading → LSR = 0x63 (OE set), RBR = second byte; a second LSR read shows OE = 0.
- IER = 0x01, receive a byte → irq = 1 and IIR = 0xC4. Read RBR → irq = 0 within 2 cycles. IER = 0x02 with the FIFO empty → irq = 1 and IIR = 0xC2.
- Hold req high across ready on a THR write, then assert rst_n = 0 mid-frame → exactly one push per accept; after reset uart_tx = 1, the FIFO is empty and LSR = 0x60.

Source files
------------

// File: rtl/uart_lite_16550.sv
// uart_lite_16550 - memory-mapped 8250/16550 register subset UART (8N1).
//
// Purpose: a small UART slave for the bus fabric. It provides a TX FIFO, a
// 16x-oversampled receiver with a single holding register, a programmable
// baud divisor and a level interrupt. Registers sit on 32-bit word
// boundaries; only addr[4:2] selects a register.
//
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   req      access request, held until ready
//   we       1 = write, 0 = read
//   addr     byte address; addr[4:2] selects the register
//   wdata    write data; the register byte is wdata[7:0]
//   wstrb    write strobes; a write takes effect only when wstrb[0] = 1
//   rdata    {24'h0, reg}; valid while ready = 1
//   ready    single-cycle completion pulse, one cycle after accept
//   uart_tx  serial output, idle high
//   uart_rx  serial input, asynchronous
//   irq      level interrupt, registered
module uart_lite_16550 #(
    parameter int          TX_DEPTH    = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        irq
);
    localparam int PW = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Register file
    logic [7:0]  dll_reg, dlm_reg, lcr_reg, mcr_reg, scr_reg, rbr_reg;
    logic [1:0]  ier_reg;
    logic        dr_reg, oe_reg, fe_reg;
    logic        ready_reg, irq_reg, uart_tx_reg;
    logic [31:0] rdata_reg;

    // TX FIFO
    logic [7:0]  fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0] count_reg;

    // Baud generator
    logic [15:0] baud_cnt_reg;

    // TX machine
    tx_state_t   tx_state_reg, tx_state_next;
    logic [3:0]  tx_cnt_reg, tx_cnt_next;
    logic [2:0]  tx_bit_reg, tx_bit_next;
    logic [7:0]  tx_shift_reg, tx_shift_next;
    logic        tx_pop;

    // RX machine
    rx_state_t   rx_state_reg, rx_state_next;
    logic [3:0]  rx_cnt_reg, rx_cnt_next;
    logic [2:0]  rx_bit_reg, rx_bit_next;
    logic [7:0]  rx_shift_reg, rx_shift_next;
    logic        rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
    logic        rx_done;

    // Bus decode
    logic [2:0]  reg_sel;
    logic        dlab, accept, wr_en, rd_en;
    logic        thr_push, fifo_clr, rx_clr, rbr_pop, lsr_rd, div_wr;
    logic        fifo_empty, fifo_full, thre, temt;
    logic [15:0] div_val, div_eff;
    logic        tick16;
    logic [7:0]  lsr_val, iir_val, rd_byte;

    assign reg_sel    = addr[4:2];
    assign dlab       = lcr_reg[7];
    assign accept     = req & ~ready_reg;
    assign wr_en      = accept & we & wstrb[0];
    assign rd_en      = accept & ~we;
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == (PW+1)'(TX_DEPTH));
    assign thr_push   = wr_en && reg_sel == 3'd0 && !dlab && !fifo_full;
    assign fifo_clr   = wr_en && reg_sel == 3'd2 && wdata[2];
    assign rx_clr     = wr_en && reg_sel == 3'd2 && wdata[1];
    assign rbr_pop    = rd_en && reg_sel == 3'd0 && !dlab;
    assign lsr_rd     = rd_en && reg_sel == 3'd5;
    assign div_wr     = wr_en && dlab && (reg_sel == 3'd0 || reg_sel == 3'd1);
    assign thre       = fifo_empty;
    assign temt       = fifo_empty && (tx_state_reg == TX_IDLE);

    // Upper address/data bits and upper strobes carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{addr[31:5], addr[1:0], wdata[31:8], wstrb[3:1]};

    // Baud tick: a zero divisor behaves like one (tick every cycle).
    assign div_val = {dlm_reg, dll_reg};
    assign div_eff = (div_val == 16'd0) ? 16'd1 : div_val;
    assign tick16  = (baud_cnt_reg == div_eff - 16'd1);

    always_ff @(posedge clk) begin
        if (!rst_n || div_wr) baud_cnt_reg <= 16'd0;
        else if (tick16)      baud_cnt_reg <= 16'd0;
        else                  baud_cnt_reg <= baud_cnt_reg + 16'd1;
    end

    // FIFO storage and pointers. A clear empties the queue; a byte already
    // loaded into the shifter still goes out.
    always_ff @(posedge clk) begin
        if (thr_push) fifo_mem[wr_ptr_reg] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || fifo_clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (thr_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (tx_pop)   rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + (PW+1)'(thr_push) - (PW+1)'(tx_pop);
        end
    end

    // TX state register; serial output is registered from the current state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= 4'd0;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'd0;
            uart_tx_reg  <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            uart_tx_reg  <= (tx_state_reg == TX_START) ? 1'b0 :
                            (tx_state_reg == TX_DATA)  ? tx_shift_reg[0] : 1'b1;
        end
    end

    // TX next state. At the end of a stop bit a waiting byte goes straight
    // into its start bit so back-to-back frames have no idle gap.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_pop        = 1'b0;
        if (tick16) begin
            case (tx_state_reg)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        tx_pop        = 1'b1;
                        tx_shift_next = fifo_mem[rd_ptr_reg];
                        tx_cnt_next   = 4'd0;
                        tx_state_next = TX_START;
                    end
                end
                TX_START: begin
                    tx_cnt_next = tx_cnt_reg + 4'd1;
                    if (tx_cnt_reg == 4'd15) begin
                        tx_bit_next   = 3'd0;
                        tx_state_next = TX_DATA;
                    end
                end
                TX_DATA: begin
                    tx_cnt_next = tx_cnt_reg + 4'd1;
                    if (tx_cnt_reg == 4'd15) begin
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        tx_bit_next   = tx_bit_reg + 3'd1;
                        if (tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
                    end
                end
                default: begin
                    tx_cnt_next = tx_cnt_reg + 4'd1;
                    if (tx_cnt_reg == 4'd15) begin
                        if (!fifo_empty) begin
                            tx_pop        = 1'b1;
                            tx_shift_next = fifo_mem[rd_ptr_reg];
                            tx_state_next = TX_START;
                        end else begin
                            tx_state_next = TX_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // RX synchronizer and state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sync1_reg <= 1'b1;
            rx_sync2_reg <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= 4'd0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'd0;
        end else begin
            rx_sync1_reg <= uart_rx;
            rx_sync2_reg <= rx_sync1_reg;
            rx_prev_reg  <= rx_sync2_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    // RX next state: the start bit is re-checked 8 ticks after the falling
    // edge (its middle); every later sample is 16 ticks on, i.e. mid-bit.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_done       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_sync2_reg) begin
                    rx_cnt_next   = 4'd0;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (tick16) begin
                    rx_cnt_next = rx_cnt_reg + 4'd1;
                    if (rx_cnt_reg == 4'd7) begin
                        rx_cnt_next   = 4'd0;
                        rx_bit_next   = 3'd0;
                        rx_state_next = rx_sync2_reg ? RX_IDLE : RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (tick16) begin
                    rx_cnt_next = rx_cnt_reg + 4'd1;
                    if (rx_cnt_reg == 4'd15) begin
                        rx_shift_next = {rx_sync2_reg, rx_shift_reg[7:1]};
                        rx_bit_next   = rx_bit_reg + 3'd1;
                        if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
                    end
                end
            end
            default: begin
                if (tick16) begin
                    rx_cnt_next = rx_cnt_reg + 4'd1;
                    if (rx_cnt_reg == 4'd15) begin
                        rx_done       = 1'b1;
                        rx_state_next = RX_IDLE;
                    end
                end
            end
        endcase
    end

    // Status and configuration registers. A byte arriving in the same cycle
    // as an RBR pop wins: DR stays set and no overrun is flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dll_reg <= DEFAULT_DIV[7:0];
            dlm_reg <= DEFAULT_DIV[15:8];
            ier_reg <= 2'd0;
            lcr_reg <= 8'd0;
            mcr_reg <= 8'd0;
            scr_reg <= 8'd0;
            rbr_reg <= 8'd0;
            dr_reg  <= 1'b0;
            oe_reg  <= 1'b0;
            fe_reg  <= 1'b0;
        end else begin
            if (wr_en) begin
                case (reg_sel)
                    3'd0: if (dlab) dll_reg <= wdata[7:0];
                    3'd1: if (dlab) dlm_reg <= wdata[7:0];
                          else      ier_reg <= wdata[1:0];
                    3'd3: lcr_reg <= wdata[7:0];
                    3'd4: mcr_reg <= wdata[7:0];
                    3'd7: scr_reg <= wdata[7:0];
                    default: ;
                endcase
            end
            if (rbr_pop) dr_reg <= 1'b0;
            if (lsr_rd) begin
                oe_reg <= 1'b0;
                fe_reg <= 1'b0;
            end
            if (rx_clr) begin
                dr_reg <= 1'b0;
                oe_reg <= 1'b0;
            end
            if (rx_done) begin
                rbr_reg <= rx_shift_reg;
                dr_reg  <= 1'b1;
                if (dr_reg && !rbr_pop && !rx_clr) oe_reg <= 1'b1;
                if (!rx_sync2_reg)                 fe_reg <= 1'b1;
            end
        end
    end

    // Read mux
    assign lsr_val = {1'b0, temt, thre, 1'b0, fe_reg, 1'b0, oe_reg, dr_reg};
    assign iir_val = (ier_reg[0] && dr_reg) ? 8'hC4 :
                     (ier_reg[1] && thre)   ? 8'hC2 : 8'hC1;

    always_comb begin
        rd_byte = 8'h00;
        case (reg_sel)
            3'd0: rd_byte = dlab ? dll_reg : rbr_reg;
            3'd1: rd_byte = dlab ? dlm_reg : {6'd0, ier_reg};
            3'd2: rd_byte = iir_val;
            3'd3: rd_byte = lcr_reg;
            3'd4: rd_byte = mcr_reg;
            3'd5: rd_byte = lsr_val;
            3'd7: rd_byte = scr_reg;
            default: rd_byte = 8'h00;
        endcase
    end

    // Bus response and interrupt
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_reg <= 1'b0;
            rdata_reg <= 32'd0;
            irq_reg   <= 1'b0;
        end else begin
            ready_reg <= accept;
            if (accept) rdata_reg <= we ? 32'd0 : {24'd0, rd_byte};
            irq_reg <= (ier_reg[0] & dr_reg) | (ier_reg[1] & thre);
        end
    end

    assign rdata   = rdata_reg;
    assign ready   = ready_reg;
    assign uart_tx = uart_tx_reg;
    assign irq     = irq_reg;

endmodule

// File: tb/tb_uart_lite_16550.sv
// tb_uart_lite_16550 - self-checking bench for uart_lite_16550.
// Read results and transmitted bytes are scoreboarded: expectations are
// queued when the stimulus is issued and compared when the DUT answers.
module tb_uart_lite_16550;
    localparam int          TX_DEPTH = 16;
    localparam logic [31:0] BASE     = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        uart_rx = 1'b1;
    logic [31:0] rdata;
    logic        ready, uart_tx, irq;

    always #5 clk = ~clk;

    uart_lite_16550 #(.TX_DEPTH(TX_DEPTH), .DEFAULT_DIV(16'd27)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
        .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
    );

    int         n_vec = 0;
    int         n_miss = 0;
    logic [7:0] rd_q [$];
    logic [7:0] tx_q [$];
    int         bit_clks = 27 * 16;
    bit         mon_en = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus access; ready must rise exactly one cycle after accept and
    // drop on the next.
    task automatic bus_xfer(input bit w, input int idx, input logic [7:0] d);
        logic [7:0] e;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = BASE + 32'(idx * 4);
        wdata = {24'h5A5A5A, d}; wstrb = 4'h1;
        wait_clks(1);
        check_eq($sformatf("ready_hi_r%0d", idx), 32'(ready), 32'd1);
        if (!w) begin
            e = rd_q.pop_front();
            check_eq($sformatf("rd_r%0d", idx), rdata, {24'd0, e});
            $display("rd reg%0d data=%02h exp=%02h", idx, rdata[7:0], e);
        end else begin
            $display("wr reg%0d data=%02h", idx, d);
        end
        req = 1'b0; we = 1'b0;
        wait_clks(1);
        check_eq($sformatf("ready_lo_r%0d", idx), 32'(ready), 32'd0);
    endtask

    task automatic wr(input int idx, input logic [7:0] d);
        bus_xfer(1'b1, idx, d);
    endtask

    task automatic rd(input int idx, input logic [7:0] exp);
        rd_q.push_back(exp);
        bus_xfer(1'b0, idx, 8'h00);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        uart_rx = 1'b0; wait_clks(bit_clks);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i]; wait_clks(bit_clks);
        end
        uart_rx = stop; wait_clks(bit_clks);
        uart_rx = 1'b1; wait_clks(4);
        $display("rx frame %02h stop=%0d", b, stop);
    endtask

    // TX monitor: decodes frames at mid-bit and checks them against tx_q.
    initial begin
        forever begin
            logic [7:0] b;
            logic       s0, s1;
            logic [7:0] e;
            @(negedge uart_tx);
            wait_clks(bit_clks / 2);
            s0 = uart_tx;
            for (int i = 0; i < 8; i++) begin
                wait_clks(bit_clks);
                b[i] = uart_tx;
            end
            wait_clks(bit_clks);
            s1 = uart_tx;
            if (mon_en) begin
                check_eq("tx_start_bit", 32'(s0), 32'd0);
                check_eq("tx_stop_bit", 32'(s1), 32'd1);
                check_eq("tx_expected", 32'(tx_q.size() > 0), 32'd1);
                if (tx_q.size() > 0) begin
                    e = tx_q.pop_front();
                    check_eq("tx_byte", 32'(b), 32'(e));
                end
                $display("tx frame %02h", b);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        wait_clks(3);
        check_eq("rst_uart_tx", 32'(uart_tx), 32'd1);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        wait_clks(2);
        rd(5, 8'h60);
        wr(3, 8'h80); rd(0, 8'd27); rd(1, 8'h00);

        // Divisor 2: one 0x55 frame, 32 clk per bit
        wr(0, 8'h02); wr(1, 8'h00); rd(0, 8'h02); wr(3, 8'h00); rd(3, 8'h00);
        bit_clks = 32;
        tx_q.push_back(8'h55);
        wr(0, 8'h55);
        begin
            int t;
            t = 0;
            while (uart_tx !== 1'b0 && t < 2000) begin wait_clks(1); t++; end
            check_eq("tx55_start_seen", 32'(uart_tx), 32'd0);
            for (int k = 0; k < 9; k++) begin
                int   w;
                logic v;
                w = 0;
                v = uart_tx;
                do begin wait_clks(1); w++; end while (uart_tx === v && w < 100);
                check_eq($sformatf("tx55_bit%0d_len", k), w, 32);
            end
        end
        rd(5, 8'h20);
        wait_clks(40);
        rd(5, 8'h60);
        check_eq("tx55_drained", tx_q.size(), 0);

        // Divisor 1: flood TX_DEPTH + 2 bytes; the last one is dropped
        wr(3, 8'h80); wr(0, 8'h01); wr(3, 8'h00);
        bit_clks = 16;
        for (int i = 0; i < TX_DEPTH + 2; i++) begin
            if (i < TX_DEPTH + 1) tx_q.push_back(8'(i));
            wr(0, 8'(i));
        end
        rd(5, 8'h00);
        begin
            int t;
            t = 0;
            while (tx_q.size() != 0 && t < 6000) begin wait_clks(1); t++; end
        end
        check_eq("flood_drained", tx_q.size(), 0);
        wait_clks(40);
        rd(5, 8'h60);

        // RX: single byte, then overrun
        send_rx(8'hA3, 1'b1);
        rd(5, 8'h61); rd(0, 8'hA3); rd(5, 8'h60);
        send_rx(8'h3C, 1'b1); send_rx(8'hC5, 1'b1);
        rd(5, 8'h63); rd(0, 8'hC5); rd(5, 8'h60);

        // Framing error, cleared by the LSR read
        send_rx(8'h81, 1'b0);
        rd(5, 8'h69); rd(5, 8'h61); rd(0, 8'h81);

        // Glitch on the line is rejected
        uart_rx = 1'b0; wait_clks(3); uart_rx = 1'b1; wait_clks(200);
        rd(5, 8'h60);

        // FCR RX clear
        send_rx(8'h11, 1'b1);
        wr(2, 8'h02);
        rd(5, 8'h60);

        // Interrupts
        wr(1, 8'h01);
        send_rx(8'h5A, 1'b1);
        check_eq("irq_rx", 32'(irq), 32'd1);
        rd(2, 8'hC4); rd(0, 8'h5A);
        wait_clks(2);
        check_eq("irq_rx_clear", 32'(irq), 32'd0);
        wr(1, 8'h02);
        wait_clks(2);
        check_eq("irq_thre", 32'(irq), 32'd1);
        rd(2, 8'hC2); rd(1, 8'h02);
        wr(1, 8'h00);
        wait_clks(2);
        check_eq("irq_off", 32'(irq), 32'd0);
        rd(2, 8'hC1);

        // req held across ready: exactly one push, then reset mid-frame
        mon_en = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = BASE; wdata = 32'h77; wstrb = 4'h1;
        wait_clks(1);
        check_eq("hold_ready_hi", 32'(ready), 32'd1);
        wait_clks(1);
        req = 1'b0; we = 1'b0;
        check_eq("hold_ready_lo", 32'(ready), 32'd0);
        $display("wr reg0 data=77 (req held across ready)");
        rd(5, 8'h20);
        wait_clks(40);
        rst_n = 1'b0;
        wait_clks(1);
        check_eq("midrst_uart_tx", 32'(uart_tx), 32'd1);
        check_eq("midrst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        wait_clks(2);
        rd(5, 8'h60);
        wait_clks(200);
        check_eq("post_rst_tx_idle", 32'(uart_tx), 32'd1);
        rd(5, 8'h60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
